// File: rtl/day3_pkg.sv
// Shared types and helpers for the input debouncer.
//   deb_state_t : qualifier FSM state (STABLE / QUALIFY)
//   deb_cnt_w() : width of the consecutive-cycle counter for a given hold time
package day3_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } deb_state_t;

    // Minimum legal synchroniser depth.
    localparam int DEB_MIN_SYNC_STAGES = 2;

    // The counter must be able to hold DEBOUNCE_CYCLES-1, so $clog2(N+1) always suffices.
    function automatic int deb_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop metastability synchroniser.
// Ports:
//   clk   in  clock
//   reset in  asynchronous active-low reset; all flops load RESET_LEVEL
//   d_i   in  asynchronous input
//   q_o   out synchronised output (last flop of the chain)
module sync_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= {STAGES{RESET_LEVEL}};
        end else begin
            r_q <= {r_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Input debouncer: synchroniser followed by a consecutive-cycle qualifier.
// a_o only follows the synchronised input once it has differed from a_o for
// DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
// Ports:
//   clk    in  clock, all state on posedge
//   reset  in  asynchronous active-low reset
//   a_i    in  raw asynchronous level
//   a_o    out debounced level (flop output)
//   busy_o out high while a candidate change is being qualified
module input_debouncer
    import day3_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic a_i,
    output logic a_o,
    output logic busy_o
);

    localparam int CNT_W = deb_cnt_w(DEBOUNCE_CYCLES);

    logic             w_s;
    logic             w_done;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a_o;
    deb_state_t       r_state;

    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (a_i),
        .q_o   (w_s)
    );

    // This cycle is the last one needed to accept the new level.
    assign w_done = ((int'(r_cnt) + 1) == DEBOUNCE_CYCLES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_o   <= RESET_LEVEL;
            r_cnt   <= '0;
            r_state <= STABLE;
        end else if (w_s == r_a_o) begin
            // bounce back (or nothing pending): drop all credit
            r_cnt   <= '0;
            r_state <= STABLE;
        end else if (w_done) begin
            r_a_o   <= w_s;
            r_cnt   <= '0;
            r_state <= STABLE;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= QUALIFY;
        end
    end

    assign a_o    = r_a_o;
    assign busy_o = (r_state == QUALIFY);

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_i = 1'b0;
    logic a_i2 = 1'b1;
    logic a_o, busy_o, a_o2, busy_o2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .RESET_LEVEL(1'b0)) dut (
        .clk(clk), .reset(rst_n), .a_i(a_i), .a_o(a_o), .busy_o(busy_o));

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b1)) dut1 (
        .clk(clk), .reset(rst_n), .a_i(a_i2), .a_o(a_o2), .busy_o(busy_o2));

    // Reference: a_i is seen SYNC edges late; a_o flips to s once the last DEB
    // observed values of s all differ from a_o. busy = a pending, unfinished run.
    logic [SYNC-1:0] m_sync;
    bit              hist[$];
    logic            m_ao, m_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sync <= '0;
            hist.delete();
            m_ao   <= 1'b0;
            m_busy <= 1'b0;
        end else begin : mdl
            automatic logic s   = m_sync[SYNC-1];
            automatic logic ao  = m_ao;
            automatic int   run = 0;
            automatic bit   all = 1'b1;
            m_sync <= {m_sync[SYNC-2:0], a_i};
            hist.push_back(s);
            if (hist.size() > DEB) void'(hist.pop_front());
            if (hist.size() == DEB) begin
                foreach (hist[i]) if (hist[i] == ao) all = 1'b0;
                if (all) ao = s;
            end
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != ao) run++;
                else break;
            end
            m_ao   <= ao;
            m_busy <= (run > 0) && (run < DEB);
        end
    end

    // Drive a_i away from the edge, then sample 1 time unit after the edge.
    task automatic cyc(input logic v);
        a_i = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_i   = 1'b0;
        a_i2  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_i   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (a_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: a_o=%b busy=%b, want 0 0", c, a_o, busy_o);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cyc(1'b1);
            checks++;
            if (a_o !== (e >= 6)) begin
                errors++;
                $display("FAIL reset_release edge%0d: a_o=%b want %b", e, a_o, (e >= 6));
            end
        end
    endtask

    task automatic test_step();
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            cyc(1'b1);
            checks++;
            if (a_o !== (e >= 6) || busy_o !== (e >= 3 && e <= 5)) begin
                errors++;
                $display("FAIL step edge%0d: a_o=%b busy=%b want %b %b",
                         e, a_o, busy_o, (e >= 6), (e >= 3 && e <= 5));
            end
            checks++;
            if (a_o !== m_ao || busy_o !== m_busy) begin
                errors++;
                $display("FAIL step_model edge%0d: a_o=%b busy=%b model %b %b", e, a_o, busy_o, m_ao, m_busy);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            cyc(e <= 3);
            checks++;
            if (a_o !== 1'b0 || busy_o !== (e >= 3 && e <= 5)) begin
                errors++;
                $display("FAIL glitch edge%0d: a_o=%b busy=%b want 0 %b", e, a_o, busy_o, (e >= 3 && e <= 5));
            end
        end
    endtask

    task automatic test_bounce();
        logic pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   rises = 0;
        logic prev;
        do_reset();
        prev = a_o;
        for (int e = 1; e <= 16; e++) begin
            cyc((e <= 5) ? pat[e-1] : 1'b1);
            if (a_o && !prev) rises++;
            prev = a_o;
            checks++;
            if (a_o !== (e >= 11) || busy_o !== m_busy) begin
                errors++;
                $display("FAIL bounce edge%0d: a_o=%b busy=%b want %b %b", e, a_o, busy_o, (e >= 11), m_busy);
            end
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL bounce_rises: got %0d want 1", rises);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 1; e <= 4; e++) cyc(1'b1);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_pre: busy=%b want 1", busy_o);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (a_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: a_o=%b busy=%b want 0 0", a_o, busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cyc(1'b1);
            checks++;
            if (a_o !== (e >= 6)) begin
                errors++;
                $display("FAIL mid_requal edge%0d: a_o=%b want %b", e, a_o, (e >= 6));
            end
        end
    endtask

    task automatic test_random();
        int   hold = 0;
        logic v = 1'b0;
        logic prev;
        int   last_tog = -100;
        do_reset();
        prev = a_o;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                v    = ~v;
                hold = $urandom_range(1, 2 * DEB + 2);
            end
            hold--;
            cyc(v);
            checks++;
            if (a_o !== m_ao || busy_o !== m_busy) begin
                errors++;
                $display("FAIL random c%0d: a_o=%b busy=%b model %b %b", c, a_o, busy_o, m_ao, m_busy);
            end
            if (a_o !== prev) begin
                checks++;
                if (c - last_tog < DEB) begin
                    errors++;
                    $display("FAIL random_spacing c%0d: toggle gap %0d want >= %0d", c, c - last_tog, DEB);
                end
                last_tog = c;
            end
            prev = a_o;
        end
    endtask

    task automatic test_d1();
        int   falls = 0;
        logic prev;
        do_reset();
        checks++;
        if (a_o2 !== 1'b1 || busy_o2 !== 1'b0) begin
            errors++;
            $display("FAIL d1_reset: a_o=%b busy=%b want 1 0", a_o2, busy_o2);
        end
        prev = a_o2;
        a_i2 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            if (!a_o2 && prev) falls++;
            prev = a_o2;
            checks++;
            if (a_o2 !== (e < 3) || busy_o2 !== 1'b0) begin
                errors++;
                $display("FAIL d1 edge%0d: a_o=%b busy=%b want %b 0", e, a_o2, busy_o2, (e < 3));
            end
        end
        checks++;
        if (falls !== 1) begin
            errors++;
            $display("FAIL d1_falls: got %0d want 1", falls);
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_random();
        test_d1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
